// File: rtl/mips_isa_pkg.sv
// rtl/mips_isa_pkg.sv - MIPS opcode/funct constants, operand formats, text tokens and ABI names
package mips_isa_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI  = 6'h0a, OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c, OP_ORI    = 6'h0d, OP_XORI  = 6'h0e, OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_COP0    = 6'h10, OP_LB     = 6'h20, OP_LH    = 6'h21, OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24, OP_LHU    = 6'h25, OP_SB    = 6'h28, OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03, FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR   = 6'h08, FN_JALR = 6'h09;
  localparam logic [5:0] FN_SYSC = 6'h0c, FN_MFHI = 6'h10, FN_MTHI = 6'h11, FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MTLO = 6'h13, FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV = 6'h1a;
  localparam logic [5:0] FN_DIVU = 6'h1b, FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23, FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27, FN_SLT  = 6'h2a, FN_SLTU = 6'h2b;

  localparam logic [4:0]  RT_BLTZ = 5'd0, RT_BGEZ = 5'd1, RS_MFC0 = 5'd0, RS_MTC0 = 5'd4;
  localparam logic [31:0] ERET_WORD = 32'h4200_0018;

  // Operand layout chosen by the decoder; the assembler walks the list in order.
  typedef enum logic [3:0] {
    F_NONE, F_DST, F_DTS, F_SHIFT, F_ST, F_D, F_S, F_DS,
    F_TSI, F_TI, F_MEM, F_STB, F_SB, F_J, F_CP0, F_RAW
  } fmt_t;

  // Short text fragment: ch[0] is the first character, len counts valid characters.
  typedef struct packed {
    logic [15:0][7:0] ch;
    logic [3:0]       len;
  } tok_t;

  localparam logic [63:0] ABI_NAME [32] = '{
    64'("$zero"), 64'("$at"), 64'("$v0"), 64'("$v1"), 64'("$a0"), 64'("$a1"), 64'("$a2"), 64'("$a3"),
    64'("$t0"),   64'("$t1"), 64'("$t2"), 64'("$t3"), 64'("$t4"), 64'("$t5"), 64'("$t6"), 64'("$t7"),
    64'("$s0"),   64'("$s1"), 64'("$s2"), 64'("$s3"), 64'("$s4"), 64'("$s5"), 64'("$s6"), 64'("$s7"),
    64'("$t8"),   64'("$t9"), 64'("$k0"), 64'("$k1"), 64'("$gp"), 64'("$sp"), 64'("$fp"), 64'("$ra")
  };

  // Turn a right-aligned, zero-padded packed literal (up to 8 chars) into a token.
  function automatic tok_t lit_tok(input logic [63:0] s);
    tok_t t;
    logic [63:0] v;
    t = '0;
    v = s;
    for (int i = 0; i < 8; i++) if (v[63:56] == 8'h00) v = v << 8;
    for (int i = 0; i < 8; i++) begin
      if (v[63-8*i -: 8] != 8'h00) begin
        t.ch[i] = v[63-8*i -: 8];
        t.len   = t.len + 4'd1;
      end
    end
    return t;
  endfunction

  // Append b after a; callers keep the combined length within 15 characters.
  function automatic tok_t cat_tok(input tok_t a, input tok_t b);
    tok_t t;
    int   j;
    t = a;
    for (int k = 0; k < 16; k++) begin
      j = k - int'(a.len);
      if (j >= 0 && j < int'(b.len)) t.ch[k] = b.ch[j[3:0]];
    end
    t.len = a.len + b.len;
    return t;
  endfunction

endpackage

// File: rtl/mips_disasm_if.sv
// rtl/mips_disasm_if.sv - fetch-side inputs and rendered text of the disassembler
interface mips_disasm_if #(parameter int ASM_CHARS = 32);
  logic [31:0]            pc;
  logic [31:0]            instr;
  logic                   imm_as_dec;
  logic                   reg_name;
  logic [8*ASM_CHARS-1:0] asm;

  modport master (output pc, instr, imm_as_dec, reg_name, input asm);
  modport slave  (input pc, instr, imm_as_dec, reg_name, output asm);
endinterface

// File: rtl/mips_disasm_fmt.sv
// rtl/mips_disasm_fmt.sv - renders decoded fields into hex/decimal/register text tokens
module disasm_fmt
  import mips_isa_pkg::*;
(
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [31:0] btgt,
  input  logic [31:0] jtgt,
  input  logic [31:0] raw,
  input  logic        imm_as_dec,
  input  logic        reg_name,
  output tok_t        rs_tok,
  output tok_t        rt_tok,
  output tok_t        rd_tok,
  output tok_t        cp0_tok,
  output tok_t        shamt_tok,
  output tok_t        imm_s_tok,
  output tok_t        imm_u_tok,
  output tok_t        mem_tok,
  output tok_t        btgt_tok,
  output tok_t        jtgt_tok,
  output tok_t        raw_tok
);

  function automatic logic [7:0] hex_digit(input logic [3:0] v);
    return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h57 + {4'h0, v});
  endfunction

  // "0x" plus the top 8 (wide) or top 4 hex digits of v.
  function automatic tok_t hex_tok(input logic [31:0] v, input logic wide);
    tok_t t;
    t = '0;
    t.ch[0] = "0";
    t.ch[1] = "x";
    for (int i = 0; i < 8; i++) t.ch[2+i] = hex_digit(v[31-4*i -: 4]);
    t.len = wide ? 4'd10 : 4'd6;
    return t;
  endfunction

  // Decimal magnitude with optional '-', leading zeros suppressed.
  function automatic tok_t dec_tok(input logic [15:0] mag, input logic neg);
    tok_t        t;
    logic [15:0] q;
    logic [3:0]  dig [5];
    logic [3:0]  n;
    logic        started;
    t = '0;
    q = mag;
    n = '0;
    started = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dig[i] = 4'(q % 16'd10);
      q      = q / 16'd10;
    end
    if (neg) begin
      t.ch[0] = "-";
      n = 4'd1;
    end
    for (int i = 4; i >= 0; i--) begin
      if (dig[i] != 4'd0 || started || i == 0) begin
        t.ch[n] = 8'h30 + {4'h0, dig[i]};
        n = n + 4'd1;
        started = 1'b1;
      end
    end
    t.len = n;
    return t;
  endfunction

  function automatic tok_t reg_tok(input logic [4:0] r, input logic abi);
    return abi ? lit_tok(ABI_NAME[r]) : cat_tok(lit_tok(64'("$")), dec_tok({11'b0, r}, 1'b0));
  endfunction

  logic [15:0] imm_mag;
  assign imm_mag = imm[15] ? (~imm + 16'd1) : imm;

  // Every operand rendering is produced in parallel; the top picks what the form needs.
  always_comb begin
    rs_tok    = reg_tok(rs, reg_name);
    rt_tok    = reg_tok(rt, reg_name);
    rd_tok    = reg_tok(rd, reg_name);
    cp0_tok   = reg_tok(rd, 1'b0);
    shamt_tok = dec_tok({11'b0, shamt}, 1'b0);
    imm_s_tok = imm_as_dec ? dec_tok(imm_mag, imm[15]) : hex_tok({imm, 16'h0}, 1'b0);
    imm_u_tok = imm_as_dec ? dec_tok(imm, 1'b0)        : hex_tok({imm, 16'h0}, 1'b0);
    mem_tok   = cat_tok(cat_tok(cat_tok(imm_s_tok, lit_tok(64'("("))), rs_tok), lit_tok(64'(")")));
    btgt_tok  = hex_tok(btgt, 1'b1);
    jtgt_tok  = hex_tok(jtgt, 1'b1);
    raw_tok   = hex_tok(raw, 1'b1);
  end

endmodule

// File: rtl/mips_disasm.sv
// rtl/mips_disasm.sv - decodes a MIPS word and registers its assembly text
module mips_disasm
  import mips_isa_pkg::*;
#(
  parameter int ASM_CHARS = 32
) (
  input  logic          clk,
  input  logic          reset,
  mips_disasm_if.slave  bus
);

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] pc4, btgt, jtgt;

  assign op    = bus.instr[31:26];
  assign rs    = bus.instr[25:21];
  assign rt    = bus.instr[20:16];
  assign rd    = bus.instr[15:11];
  assign shamt = bus.instr[10:6];
  assign funct = bus.instr[5:0];
  assign imm   = bus.instr[15:0];
  assign pc4   = bus.pc + 32'd4;
  assign btgt  = pc4 + {{14{imm[15]}}, imm, 2'b00};
  assign jtgt  = {pc4[31:28], bus.instr[25:0], 2'b00};

  tok_t rs_tok, rt_tok, rd_tok, cp0_tok, shamt_tok, imm_s_tok, imm_u_tok;
  tok_t mem_tok, btgt_tok, jtgt_tok, raw_tok;

  disasm_fmt u_fmt (
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm),
    .btgt(btgt), .jtgt(jtgt), .raw(bus.instr),
    .imm_as_dec(bus.imm_as_dec), .reg_name(bus.reg_name),
    .rs_tok(rs_tok), .rt_tok(rt_tok), .rd_tok(rd_tok), .cp0_tok(cp0_tok),
    .shamt_tok(shamt_tok), .imm_s_tok(imm_s_tok), .imm_u_tok(imm_u_tok),
    .mem_tok(mem_tok), .btgt_tok(btgt_tok), .jtgt_tok(jtgt_tok), .raw_tok(raw_tok)
  );

  logic [63:0] mnem;
  fmt_t        fmt;
  logic        imm_signed;

  // Mnemonic and operand form; anything not matched falls through to "unknown <raw>".
  always_comb begin
    mnem = 64'("unknown");
    fmt = F_RAW;
    imm_signed = 1'b0;
    case (op)
      OP_SPECIAL: case (funct)
        FN_SLL:   begin mnem = 64'("sll");   fmt = F_SHIFT; end
        FN_SRL:   begin mnem = 64'("srl");   fmt = F_SHIFT; end
        FN_SRA:   begin mnem = 64'("sra");   fmt = F_SHIFT; end
        FN_SLLV:  begin mnem = 64'("sllv");  fmt = F_DTS; end
        FN_SRLV:  begin mnem = 64'("srlv");  fmt = F_DTS; end
        FN_SRAV:  begin mnem = 64'("srav");  fmt = F_DTS; end
        FN_JR:    begin mnem = 64'("jr");    fmt = F_S; end
        FN_JALR:  begin mnem = 64'("jalr");  fmt = F_DS; end
        FN_SYSC:  begin mnem = 64'("syscall"); fmt = F_NONE; end
        FN_MFHI:  begin mnem = 64'("mfhi");  fmt = F_D; end
        FN_MTHI:  begin mnem = 64'("mthi");  fmt = F_S; end
        FN_MFLO:  begin mnem = 64'("mflo");  fmt = F_D; end
        FN_MTLO:  begin mnem = 64'("mtlo");  fmt = F_S; end
        FN_MULT:  begin mnem = 64'("mult");  fmt = F_ST; end
        FN_MULTU: begin mnem = 64'("multu"); fmt = F_ST; end
        FN_DIV:   begin mnem = 64'("div");   fmt = F_ST; end
        FN_DIVU:  begin mnem = 64'("divu");  fmt = F_ST; end
        FN_ADD:   begin mnem = 64'("add");   fmt = F_DST; end
        FN_ADDU:  begin mnem = 64'("addu");  fmt = F_DST; end
        FN_SUB:   begin mnem = 64'("sub");   fmt = F_DST; end
        FN_SUBU:  begin mnem = 64'("subu");  fmt = F_DST; end
        FN_AND:   begin mnem = 64'("and");   fmt = F_DST; end
        FN_OR:    begin mnem = 64'("or");    fmt = F_DST; end
        FN_XOR:   begin mnem = 64'("xor");   fmt = F_DST; end
        FN_NOR:   begin mnem = 64'("nor");   fmt = F_DST; end
        FN_SLT:   begin mnem = 64'("slt");   fmt = F_DST; end
        FN_SLTU:  begin mnem = 64'("sltu");  fmt = F_DST; end
        default:  ;
      endcase
      OP_REGIMM: begin
        if (rt == RT_BLTZ)      begin mnem = 64'("bltz"); fmt = F_SB; end
        else if (rt == RT_BGEZ) begin mnem = 64'("bgez"); fmt = F_SB; end
      end
      OP_J:     begin mnem = 64'("j");     fmt = F_J; end
      OP_JAL:   begin mnem = 64'("jal");   fmt = F_J; end
      OP_BEQ:   begin mnem = 64'("beq");   fmt = F_STB; end
      OP_BNE:   begin mnem = 64'("bne");   fmt = F_STB; end
      OP_BLEZ:  begin mnem = 64'("blez");  fmt = F_SB; end
      OP_BGTZ:  begin mnem = 64'("bgtz");  fmt = F_SB; end
      OP_ADDI:  begin mnem = 64'("addi");  fmt = F_TSI; imm_signed = 1'b1; end
      OP_ADDIU: begin mnem = 64'("addiu"); fmt = F_TSI; imm_signed = 1'b1; end
      OP_SLTI:  begin mnem = 64'("slti");  fmt = F_TSI; imm_signed = 1'b1; end
      OP_SLTIU: begin mnem = 64'("sltiu"); fmt = F_TSI; imm_signed = 1'b1; end
      OP_ANDI:  begin mnem = 64'("andi");  fmt = F_TSI; end
      OP_ORI:   begin mnem = 64'("ori");   fmt = F_TSI; end
      OP_XORI:  begin mnem = 64'("xori");  fmt = F_TSI; end
      OP_LUI:   begin mnem = 64'("lui");   fmt = F_TI; end
      OP_COP0: begin
        if (bus.instr == ERET_WORD)  begin mnem = 64'("eret"); fmt = F_NONE; end
        else if (rs == RS_MFC0)      begin mnem = 64'("mfc0"); fmt = F_CP0; end
        else if (rs == RS_MTC0)      begin mnem = 64'("mtc0"); fmt = F_CP0; end
      end
      OP_LB:    begin mnem = 64'("lb");    fmt = F_MEM; end
      OP_LH:    begin mnem = 64'("lh");    fmt = F_MEM; end
      OP_LW:    begin mnem = 64'("lw");    fmt = F_MEM; end
      OP_LBU:   begin mnem = 64'("lbu");   fmt = F_MEM; end
      OP_LHU:   begin mnem = 64'("lhu");   fmt = F_MEM; end
      OP_SB:    begin mnem = 64'("sb");    fmt = F_MEM; end
      OP_SH:    begin mnem = 64'("sh");    fmt = F_MEM; end
      OP_SW:    begin mnem = 64'("sw");    fmt = F_MEM; end
      default:  ;
    endcase
    if (bus.instr == 32'h0) begin
      mnem = 64'("nop");
      fmt = F_NONE;
    end
  end

  // Copy a token into the line at character position pos; characters past the end are dropped.
  function automatic logic [8*ASM_CHARS-1:0] put_tok(input logic [8*ASM_CHARS-1:0] line_in,
                                                     input int pos, input tok_t t);
    logic [8*ASM_CHARS-1:0] l;
    int j;
    l = line_in;
    for (int k = 0; k < ASM_CHARS; k++) begin
      j = k - pos;
      if (j >= 0 && j < int'(t.len)) l[8*(ASM_CHARS-1-k) +: 8] = t.ch[j[3:0]];
    end
    return l;
  endfunction

  tok_t                   ops [3];
  tok_t                   mn_tok, sep;
  logic [1:0]             nops;
  logic [8*ASM_CHARS-1:0] line;
  int                     pos;

  // Pick the operand tokens for the form, then lay out "mnem op1, op2, op3".
  always_comb begin
    for (int i = 0; i < 3; i++) ops[i] = '0;
    nops = 2'd0;
    case (fmt)
      F_DST:   begin ops[0] = rd_tok; ops[1] = rs_tok; ops[2] = rt_tok;    nops = 2'd3; end
      F_DTS:   begin ops[0] = rd_tok; ops[1] = rt_tok; ops[2] = rs_tok;    nops = 2'd3; end
      F_SHIFT: begin ops[0] = rd_tok; ops[1] = rt_tok; ops[2] = shamt_tok; nops = 2'd3; end
      F_ST:    begin ops[0] = rs_tok; ops[1] = rt_tok;                     nops = 2'd2; end
      F_D:     begin ops[0] = rd_tok;                                      nops = 2'd1; end
      F_S:     begin ops[0] = rs_tok;                                      nops = 2'd1; end
      F_DS:    begin ops[0] = rd_tok; ops[1] = rs_tok;                     nops = 2'd2; end
      F_TSI:   begin ops[0] = rt_tok; ops[1] = rs_tok;
                     ops[2] = imm_signed ? imm_s_tok : imm_u_tok;          nops = 2'd3; end
      F_TI:    begin ops[0] = rt_tok; ops[1] = imm_u_tok;                  nops = 2'd2; end
      F_MEM:   begin ops[0] = rt_tok; ops[1] = mem_tok;                    nops = 2'd2; end
      F_STB:   begin ops[0] = rs_tok; ops[1] = rt_tok; ops[2] = btgt_tok;  nops = 2'd3; end
      F_SB:    begin ops[0] = rs_tok; ops[1] = btgt_tok;                   nops = 2'd2; end
      F_J:     begin ops[0] = jtgt_tok;                                    nops = 2'd1; end
      F_CP0:   begin ops[0] = rt_tok; ops[1] = cp0_tok;                    nops = 2'd2; end
      F_RAW:   begin ops[0] = raw_tok;                                     nops = 2'd1; end
      default: ;
    endcase
    mn_tok = lit_tok(mnem);
    sep = '0;
    line = {ASM_CHARS{8'h20}};
    pos = 0;
    line = put_tok(line, pos, mn_tok);
    pos = pos + int'(mn_tok.len);
    for (int i = 0; i < 3; i++) begin
      if (i < int'(nops)) begin
        sep = (i == 0) ? lit_tok(64'(" ")) : lit_tok(64'(", "));
        line = put_tok(line, pos, sep);
        pos = pos + int'(sep.len);
        line = put_tok(line, pos, ops[i]);
        pos = pos + int'(ops[i].len);
      end
    end
  end

  // Output register; reset blanks the line.
  always_ff @(posedge clk) begin
    if (!reset) bus.asm <= {ASM_CHARS{8'h20}};
    else        bus.asm <= line;
  end

endmodule

// File: tb/tb_mips_disasm.sv
// tb/tb_mips_disasm.sv - scoreboard bench for mips_disasm with directed vectors
module tb_mips_disasm;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_disasm_if #(.ASM_CHARS(32)) bus ();
  mips_disasm #(.ASM_CHARS(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [255:0] exp_q [$];
  string        name_q [$];
  int           n_checks = 0;
  int           n_fail = 0;
  logic [255:0] mon_exp;
  string        mon_name;

  function automatic logic [255:0] pad(input string s);
    logic [255:0] r;
    r = {32{8'h20}};
    for (int i = 0; i < s.len() && i < 32; i++) r[255-8*i -: 8] = s[i];
    return r;
  endfunction

  // Drive one cycle of inputs and queue the line expected after the next rising edge.
  task automatic drive(input logic rst, input logic [31:0] p, input logic [31:0] ins,
                       input logic dec, input logic abi, input string exp, input string nm);
    @(negedge clk);
    reset = rst;
    bus.pc = p;
    bus.instr = ins;
    bus.imm_as_dec = dec;
    bus.reg_name = abi;
    exp_q.push_back(rst ? pad(exp) : {32{8'h20}});
    name_q.push_back(nm);
  endtask

  // Monitor: one queued expectation is consumed per rising edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_name = name_q.pop_front();
      n_checks++;
      if (bus.asm !== mon_exp) begin
        n_fail++;
        $display("FAIL %s: asm=\"%s\" expected=\"%s\"", mon_name, bus.asm, mon_exp);
      end
    end
  end

  initial begin
    reset = 1'b0;
    bus.pc = 32'h0;
    bus.instr = 32'h0;
    bus.imm_as_dec = 1'b0;
    bus.reg_name = 1'b0;

    drive(0, 32'h0, 32'h0022_1821, 0, 0, "", "reset_c0");
    drive(0, 32'h0, 32'h0022_1821, 0, 0, "", "reset_c1");
    drive(1, 32'h0, 32'h0022_1821, 0, 0, "addu $3, $1, $2", "addu_num");
    drive(1, 32'h0, 32'h0022_1821, 0, 1, "addu $v1, $at, $v0", "addu_abi");
    drive(1, 32'h0, 32'h3401_1234, 0, 0, "ori $1, $0, 0x1234", "ori_hex");
    drive(1, 32'h0, 32'h3401_1234, 1, 0, "ori $1, $0, 4660", "ori_dec");
    drive(1, 32'h0, 32'h8FA2_FFFC, 1, 0, "lw $2, -4($29)", "lw_dec");
    drive(1, 32'h0, 32'h8FA2_FFFC, 0, 0, "lw $2, 0xfffc($29)", "lw_hex");
    drive(1, 32'h0, 32'h8FA2_FFFC, 1, 1, "lw $v0, -4($sp)", "lw_abi");
    drive(1, 32'h3000, 32'h1022_0003, 0, 0, "beq $1, $2, 0x00003010", "beq_fwd");
    drive(1, 32'h3000, 32'h0800_0C10, 0, 0, "j 0x00003040", "j");
    drive(1, 32'h3000, 32'h1020_FFFF, 0, 0, "beq $1, $0, 0x00003000", "beq_back");
    drive(1, 32'h3000, 32'h0460_0001, 0, 0, "bltz $3, 0x00003008", "bltz");
    drive(1, 32'h0, 32'h1820_8000, 0, 0, "blez $1, 0xfffe0004", "blez_wrap");
    drive(1, 32'hF000_0000, 32'h0C00_0001, 0, 0, "jal 0xf0000004", "jal_region");
    drive(1, 32'h0, 32'h0000_0000, 0, 0, "nop", "nop");
    drive(1, 32'h0, 32'h4200_0018, 0, 0, "eret", "eret");
    drive(1, 32'h0, 32'h4008_6000, 0, 0, "mfc0 $8, $12", "mfc0");
    drive(1, 32'h0, 32'h4088_6000, 0, 1, "mtc0 $t0, $12", "mtc0_abi");
    drive(1, 32'h0, 32'hFC00_0000, 0, 0, "unknown 0xfc000000", "unknown_op");
    drive(1, 32'h0, 32'h0000_0001, 0, 0, "unknown 0x00000001", "unknown_funct");
    drive(1, 32'h0, 32'h0002_17C0, 1, 0, "sll $2, $2, 31", "sll_max");
    drive(1, 32'h0, 32'h2008_8000, 1, 0, "addi $8, $0, -32768", "addi_min_dec");
    drive(1, 32'h0, 32'h2008_8000, 0, 0, "addi $8, $0, 0x8000", "addi_min_hex");
    drive(1, 32'h0, 32'h3108_FFFF, 1, 0, "andi $8, $8, 65535", "andi_max");
    drive(1, 32'h0, 32'h3C01_FFFF, 1, 0, "lui $1, 65535", "lui_dec");
    drive(1, 32'h0, 32'h0062_0804, 0, 0, "sllv $1, $2, $3", "sllv");
    drive(1, 32'h0, 32'h0085_001A, 0, 0, "div $4, $5", "div");
    drive(1, 32'h0, 32'h0000_1012, 0, 0, "mflo $2", "mflo");
    drive(1, 32'h0, 32'h03E0_0008, 0, 1, "jr $ra", "jr_abi");
    drive(1, 32'h0, 32'h0120_F809, 0, 1, "jalr $ra, $t1", "jalr_abi");
    drive(1, 32'h0, 32'h0000_000C, 0, 0, "syscall", "syscall");
    drive(1, 32'h0, 32'hA3A8_0010, 0, 1, "sb $t0, 0x0010($sp)", "sb_abi");
    drive(0, 32'h0, 32'h3401_1234, 0, 0, "", "reset_mid");
    drive(1, 32'h0, 32'h3401_1234, 0, 0, "ori $1, $0, 0x1234", "after_reset");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_disasm.md
Name: mips_disasm

Overview:
- Simulation/debug-side MIPS instruction disassembler.
- Takes the fetch-stage PC and 32-bit instruction and renders a human-readable assembly string: mnemonic plus operands, ASCII, one character per byte.
- Sits beside the instruction fetch unit for waveform and debug visibility only; it has no architectural effect and no other logic consumes its output.

Parameters:
- ASM_CHARS, 32, number of ASCII characters in the output string; the asm port width is 8*ASM_CHARS.

Ports:
- clk  input  1  system clock; all state is on the rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- pc  input  32  address of instr; used to compute branch and jump targets.
- instr  input  32  instruction word to decode.
- imm_as_dec  input  1  1 = 16-bit immediates printed in decimal; 0 = printed as "0x" plus 4 hex digits.
- reg_name  input  1  1 = ABI register names ($zero,$at,$v0..$ra); 0 = numeric names ($0..$31).
- asm  output  8*ASM_CHARS  rendered text. The first character is in bits [8*ASM_CHARS-1 -: 8]. Text is left-justified and right-padded with spaces (0x20).

Behaviour:
- Reset and latency
  - Output is registered with 1-cycle latency: asm after a rising edge reflects the pc, instr and option inputs sampled at that edge.
  - reset==0 at a rising edge: asm becomes all spaces. Reset overrides any decode in that cycle.
  - Decoding resumes on the first edge with reset==1.
- Decode fields
  - op=instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm=[15:0], index=[25:0].
- Instruction forms (operand separator is ", ")
  - instr==0: "nop".
  - R-type three-register: add addu sub subu and or xor nor slt sltu → "mnem rd, rs, rt".
  - Variable shifts: sllv srlv srav → "mnem rd, rt, rs".
  - Constant shifts: sll srl sra → "mnem rd, rt, shamt"; shamt always unsigned decimal.
  - mult multu div divu → "mnem rs, rt".
  - mfhi mflo → "mnem rd"; mthi mtlo jr → "mnem rs".
  - jalr → "jalr rd, rs"; syscall → "syscall".
  - Sign-extended ALU immediates: addi addiu slti sltiu → "mnem rt, rs, imm"; decimal form is signed (e.g. -4).
  - Zero-extended ALU immediates: andi ori xori → "mnem rt, rs, imm"; decimal form is unsigned.
  - lui → "lui rt, imm" (unsigned).
  - Loads/stores: lw lh lhu lb lbu sw sh sb → "mnem rt, imm(rs)"; offset signed in decimal form.
  - Branches with two registers: beq bne → "mnem rs, rt, 0xTTTTTTTT".
  - Branches with one register: blez bgtz bltz bgez → "mnem rs, 0xTTTTTTTT". bltz/bgez are distinguished by op=1 with rt=0 or rt=1.
  - Branch target = pc + 4 + (sext(imm) << 2), mod 2^32.
  - j jal → "mnem 0xTTTTTTTT", target = {(pc+4)[31:28], index, 2'b00}.
- Coprocessor 0
  - mfc0 → "mfc0 rt, $rd"; mtc0 → "mtc0 rt, $rd". The CP0 register is always numeric decimal.
  - eret (0x42000018) → "eret".
- Fallbacks and formatting rules
  - Any unrecognised encoding → "unknown 0xXXXXXXXX" (raw word).
  - Hex digits are lowercase; target addresses are 8 hex digits.
  - Decimal values have no leading zeros; negative values use a leading '-'.
  - Text longer than ASM_CHARS is truncated at the right.

Decomposition:
- Shared package mips_isa_pkg holds opcode, funct and rt/rs selector constants, plus the 32-entry ABI register name table.
- One sub-module, disasm_fmt, holds the pure-function helpers: hex digit/word, decimal (signed/unsigned) and register-name rendering into a fixed-width char buffer.
- The top level does the field decode, the mnemonic and format select, and the output register.

Test Plan:
- reset=0 for 2 cycles with instr=0x00221821 → asm all spaces; then reset=1 for one cycle → "addu $3, $1, $2"; with reg_name=1 → "addu $v1, $at, $v0".
- instr=0x34011234 with imm_as_dec=0 → "ori $1, $0, 0x1234"; with imm_as_dec=1 → "ori $1, $0, 4660".
- instr=0x8FA2FFFC, imm_as_dec=1 → "lw $2, -4($29)"; with imm_as_dec=0 → "lw $2, 0xfffc($29)".
- pc=0x00003000:
  - instr=0x10220003 → "beq $1, $2, 0x00003010".
  - instr=0x08000C10 → "j 0x00003040".
  - instr=0x1020FFFF → "beq $1, $0, 0x00003000".
- instr=0x00000000 → "nop"; 0x42000018 → "eret"; 0x40086000 → "mfc0 $8, $12"; 0xFC000000 → "unknown 0xfc000000".
- Latency: change instr on every edge → asm lags instr by exactly one cycle. Assert reset=0 mid-stream → spaces on the next edge.
